// File: rtl/search_arbiter_if.sv
// Bundle between search_arbiter and its environment: requester handshake/results plus
// the binary-search engine start/value/found/notfound/addr signals.
interface search_arbiter_if #(
    parameter int unsigned NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] value_in;
    logic [NREQ-1:0]   ack;
    logic              res_found;
    logic [4:0]        res_addr;
    logic [2:0]        res_id;
    logic              res_timeout;
    logic              busy;
    logic              eng_start;
    logic [7:0]        eng_value;
    logic              eng_found;
    logic              eng_notfound;
    logic [4:0]        eng_addr;

    // Environment side: requesters and the search engine.
    modport master (
        output req, value_in, eng_found, eng_notfound, eng_addr,
        input  ack, res_found, res_addr, res_id, res_timeout, busy, eng_start, eng_value
    );

    // Arbiter side.
    modport slave (
        input  req, value_in, eng_found, eng_notfound, eng_addr,
        output ack, res_found, res_addr, res_id, res_timeout, busy, eng_start, eng_value
    );
endinterface

// File: rtl/search_arbiter.sv
// Round-robin arbiter sharing one binary-search engine among NREQ requesters.
// Optional WAIT watchdog enabled by defining SEARCH_TIMEOUT_EN.
module search_arbiter #(
    parameter int unsigned NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic            clk,
    input logic            reset,
    search_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StGrant, StWait, StRelease} state_e;

    state_e          state_q, state_d;
    logic [2:0]      rr_q, rr_d;
    logic [2:0]      sel_q, sel_d;
    logic [7:0]      key_q, key_d;
    logic            start_q, start_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            found_q, found_d;
    logic [4:0]      addr_q, addr_d;
    logic [2:0]      id_q, id_d;

`ifdef SEARCH_TIMEOUT_EN
    logic [7:0]      cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`else
    logic [31:0]     unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    logic [2*NREQ-1:0] req_dbl, req_shift;
    logic [NREQ-1:0]   req_rot;
    logic              pick_valid;
    logic [2:0]        pick_idx;
    logic [7:0]        pick_key;
    logic [3:0]        pick_sum;
    logic [NREQ-1:0]   sel_onehot;
    logic [3:0]        rr_next;
    logic              finish;

    // Rotate requests so bit 0 is the requester at the round-robin pointer.
    always_comb begin
        req_dbl    = {bus.req, bus.req};
        req_shift  = req_dbl >> rr_q;
        req_rot    = req_shift[NREQ-1:0];
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_sum   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!pick_valid && req_rot[j]) begin
                pick_valid = 1'b1;
                pick_sum   = 4'(rr_q) + 4'(j);
                if (pick_sum >= 4'(NREQ)) begin
                    pick_sum = pick_sum - 4'(NREQ);
                end
                pick_idx = pick_sum[2:0];
            end
        end
        pick_key = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (3'(k) == pick_idx) begin
                pick_key = bus.value_in[k*8 +: 8];
            end
        end
        sel_onehot = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel_onehot[k] = (3'(k) == sel_q);
        end
        rr_next = 4'(sel_q) + 4'd1;
        if (rr_next >= 4'(NREQ)) begin
            rr_next = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        key_d   = key_q;
        start_d = start_q;
        ack_d   = '0;
        found_d = found_q;
        addr_d  = addr_q;
        id_d    = id_q;
        finish  = 1'b0;
`ifdef SEARCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    sel_d   = pick_idx;
                    key_d   = pick_key;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                start_d = 1'b1;
                state_d = StWait;
`ifdef SEARCH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                // found wins when the engine raises both flags.
                if (bus.eng_found || bus.eng_notfound) begin
                    found_d = bus.eng_found;
                    addr_d  = bus.eng_found ? bus.eng_addr : 5'd0;
                    finish  = 1'b1;
`ifdef SEARCH_TIMEOUT_EN
                    tmo_d   = 1'b0;
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    found_d = 1'b0;
                    addr_d  = 5'd0;
                    tmo_d   = 1'b1;
                    finish  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
`endif
                end
                if (finish) begin
                    ack_d   = sel_onehot;
                    id_d    = sel_q;
                    start_d = 1'b0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (!bus.eng_found && !bus.eng_notfound) begin
                    rr_d    = rr_next[2:0];
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rr_q    <= '0;
            sel_q   <= '0;
            key_q   <= '0;
            start_q <= 1'b0;
            ack_q   <= '0;
            found_q <= 1'b0;
            addr_q  <= '0;
            id_q    <= '0;
`ifdef SEARCH_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            key_q   <= key_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            found_q <= found_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
`ifdef SEARCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.ack       = ack_q;
    assign bus.res_found = found_q;
    assign bus.res_addr  = addr_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.eng_start = start_q;
    assign bus.eng_value = key_q;
`ifdef SEARCH_TIMEOUT_EN
    assign bus.res_timeout = tmo_q;
`else
    assign bus.res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_search_arbiter.sv
// Bench for search_arbiter: behavioural search engine over a ROM of mem[i]=i, round-robin
// reference model feeding a scoreboard queue, and a monitor that checks every ack.
module tb_search_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned TMO  = 8;

    typedef struct packed {
        logic [NREQ-1:0] ack;
        logic            found;
        logic [4:0]      addr;
        logic [2:0]      id;
        logic            tmo;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    search_arbiter_if #(.NREQ(NREQ)) bus ();

    search_arbiter #(
        .NREQ(NREQ),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t exp_q[$];
    int   rr_m     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, want);
    endtask

    // Behavioural engine: binary search over a sorted 32-entry ROM, holds result until start drops.
    logic [7:0] mem [32];
    int         eng_lat  = 0;
    int         eng_cnt  = 0;
    bit         eng_done = 0;
    bit         eng_mute = 0;
    bit         eng_both = 0;
    bit         e_hit;
    logic [4:0] e_addr;

    function automatic void bsearch(input logic [7:0] key, output bit hit, output logic [4:0] a);
        int lo = 0;
        int hi = 31;
        int mid;
        hit = 0;
        a   = '0;
        while (lo <= hi) begin
            mid = (lo + hi) / 2;
            if (mem[mid] == key) begin
                hit = 1;
                a   = 5'(mid);
                break;
            end else if (mem[mid] < key) lo = mid + 1;
            else hi = mid - 1;
        end
    endfunction

    always @(posedge clk) begin
        if (bus.eng_start !== 1'b1) begin
            bus.eng_found    <= 1'b0;
            bus.eng_notfound <= 1'b0;
            bus.eng_addr     <= '0;
            eng_cnt          <= 0;
            eng_done         <= 0;
        end else if (!eng_done && !eng_mute) begin
            if (eng_cnt >= eng_lat) begin
                bsearch(bus.eng_value, e_hit, e_addr);
                bus.eng_found    <= e_hit;
                bus.eng_notfound <= !e_hit || eng_both;
                bus.eng_addr     <= e_hit ? e_addr : 5'($urandom);
                eng_done         <= 1;
            end else begin
                eng_cnt <= eng_cnt + 1;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks result hold between acks.
    logic [NREQ-1:0] ack_prev;
    logic            busy_prev;
    exp_t            last;
    exp_t            e;

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            ack_prev  = '0;
            busy_prev = 1'b0;
            last      = '0;
        end else begin
            if (bus.ack != '0) begin
                check("ack_onehot", $countones(bus.ack), 1);
                check("ack_one_cycle", 32'(ack_prev), 0);
                if (exp_q.size() == 0) begin
                    check("ack_unexpected", 32'(bus.ack), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_bits", 32'(bus.ack), 32'(e.ack));
                    check("res_found", 32'(bus.res_found), 32'(e.found));
                    check("res_addr", 32'(bus.res_addr), 32'(e.addr));
                    check("res_id", 32'(bus.res_id), 32'(e.id));
                    check("res_timeout", 32'(bus.res_timeout), 32'(e.tmo));
                    last = e;
                end
            end else begin
                check("res_hold", {bus.res_found, bus.res_addr, bus.res_id, bus.res_timeout},
                      {last.found, last.addr, last.id, last.tmo});
            end
            if (busy_prev && !bus.busy) begin
                check("eng_clear_before_idle", {bus.eng_found, bus.eng_notfound}, 0);
            end
            ack_prev  = bus.ack;
            busy_prev = bus.busy;
        end
    end

    // Reference: each grant goes to the first requester with searches left, from the pointer up.
    task automatic model_round(input int cnt [NREQ], input logic [7:0] keys [NREQ]);
        int   left [NREQ];
        int   total = 0;
        int   j;
        exp_t x;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = cnt[i];
            total  += cnt[i];
        end
        while (total > 0) begin
            j = rr_m;
            while (left[j] == 0) j = (j + 1) % NREQ;
            x       = '0;
            x.ack[j] = 1'b1;
            x.found = (keys[j] < 8'd32);
            x.addr  = x.found ? keys[j][4:0] : 5'd0;
            x.id    = 3'(j);
            exp_q.push_back(x);
            left[j]--;
            total--;
            rr_m = (j + 1) % NREQ;
        end
    endtask

    task automatic run_round(input int cnt [NREQ], input logic [7:0] keys [NREQ], input int lat);
        int rem [NREQ];
        int rem_total = 0;
        int cyc = 0;
        model_round(cnt, keys);
        eng_lat = lat;
        @(negedge clk);
        check("idle_before_round", 32'(bus.busy), 0);
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = cnt[i];
            rem_total += cnt[i];
            bus.value_in[i*8 +: 8] = keys[i];
            bus.req[i] = (cnt[i] > 0);
        end
        @(posedge clk);
        #1;
        check("start_low_after_1", 32'(bus.eng_start), 0);
        check("busy_after_1", 32'(bus.busy), 1);
        @(posedge clk);
        #1;
        check("start_high_after_2", 32'(bus.eng_start), 1);
        while (rem_total > 0 && cyc < 200 * (cnt[0] + cnt[1])) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i] && rem[i] > 0) begin
                    rem[i]--;
                    rem_total--;
                    if (rem[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
        check("round_served", rem_total, 0);
        bus.req = '0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        exp_q.delete();
        rr_m = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int         rc [NREQ];
    logic [7:0] rk [NREQ];
    int         n;
    exp_t       tx;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i);
        reset        = 1'b1;
        bus.req      = '0;
        bus.value_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 0);
        check("rst_found", 32'(bus.res_found), 0);
        check("rst_addr", 32'(bus.res_addr), 0);
        check("rst_id", 32'(bus.res_id), 0);
        check("rst_timeout", 32'(bus.res_timeout), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_start", 32'(bus.eng_start), 0);
        check("rst_value", 32'(bus.eng_value), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_round('{1, 0}, '{8'd25, 8'd0}, 2);
        run_round('{0, 1}, '{8'd0, 8'd33}, 1);
        run_round('{2, 2}, '{8'd5, 8'd20}, 0);
        run_round('{1, 0}, '{8'd0, 8'd9}, 3);
        run_round('{0, 1}, '{8'd4, 8'd31}, 1);
        eng_both = 1;
        run_round('{1, 1}, '{8'd7, 8'd12}, 1);
        eng_both = 0;

        // Reset on the third cycle of a long search, then the same key again.
        eng_lat = 20;
        @(negedge clk);
        bus.value_in[7:0] = 8'd17;
        bus.req = 2'b01;
        n = 0;
        while (bus.eng_start !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_started", 32'(bus.eng_start), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_start", 32'(bus.eng_start), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_ack", 32'(bus.ack), 0);
        bus.req = '0;
        exp_q.delete();
        rr_m = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_round('{1, 0}, '{8'd17, 8'd0}, 1);

`ifdef SEARCH_TIMEOUT_EN
        eng_mute = 1;
        tx = '0;
        tx.ack[0] = 1'b1;
        tx.tmo = 1'b1;
        exp_q.push_back(tx);
        rr_m = 1;
        @(negedge clk);
        bus.value_in[7:0] = 8'd9;
        bus.req = 2'b01;
        n = 0;
        for (int c = 0; c < 100 && bus.ack == '0; c++) begin
            @(negedge clk);
            if (bus.ack == '0 && bus.eng_start) n++;
        end
        check("timeout_wait_cycles", n, TMO);
        bus.req = '0;
        eng_mute = 0;
        repeat (4) @(negedge clk);
        run_round('{1, 0}, '{8'd3, 8'd0}, 1);
`else
        eng_mute = 1;
        @(negedge clk);
        bus.value_in[7:0] = 8'd9;
        bus.req = 2'b01;
        repeat (100) @(negedge clk);
        check("stub_busy_held", 32'(bus.busy), 1);
        check("stub_no_timeout", 32'(bus.res_timeout), 0);
        eng_mute = 0;
        do_reset();
`endif

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                rc[i] = int'($urandom_range(0, 3));
                rk[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
            end
            if (rc[0] + rc[1] == 0) rc[$urandom_range(0, 1)] = 1;
            run_round(rc, rk, int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
